relu_maxpool: RTL and testbench

- Downstream stage of conv_op. Consumes the conv_op output pixel stream in raster order and applies ReLU followed by 2x2 max-pooling with stride 2.
- Emits pooled pixels in raster order to the next layer, with a valid/ready handshake on both sides.
- Pooling uses one pooled-row line buffer, so row-major input streams through without a full-frame store.

---
 rtl/relu_maxpool_pkg.sv | 18 +
 rtl/relu_maxpool_linebuf.sv | 38 +++
 rtl/relu_maxpool.sv | 119 +++++++++++
 tb/tb_relu_maxpool.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_maxpool_pkg.sv
// relu_maxpool_pkg: shared constants and helpers for the ReLU + 2x2 max-pool stage.
//   OUTPUT_BITWIDTH : conv_op output word width, the default pixel width here.
//   IMG_W, KERNEL_W : image width and kernel size; they set the conv feature-map size.
//   clog2_min1      : index width helper that never returns 0.
package relu_maxpool_pkg;

    localparam int OUTPUT_BITWIDTH = 16;
    localparam int IMG_W           = 7;
    localparam int KERNEL_W        = 3;
    localparam int DEF_FMAP        = IMG_W - KERNEL_W + 1;

    // Width of a counter or index that must hold the values 0..n-1.
    // The result is at least 1 bit, so a degenerate size still gives a legal vector.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/relu_maxpool_linebuf.sv
// pool_linebuf: one pooled row of partial maxima. It holds the max of each row pair's top row.
//   clk, rst    : clock and asynchronous active-high reset. Reset clears every entry.
//   wr_en_i     : write strobe.
//   wr_idx_i    : pool column to write.
//   wr_data_i   : partial max to store.
//   rd_idx_i    : pool column to read. The read is asynchronous.
//   rd_data_o   : stored partial max. It reads as 0 for an index past the end.
module pool_linebuf
    import relu_maxpool_pkg::*;
#(
    parameter int DATA_W = OUTPUT_BITWIDTH,
    parameter int POOL_W = DEF_FMAP / 2,
    parameter int IDX_W  = clog2_min1(POOL_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [POOL_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < POOL_W; i++) mem_q[i] <= '0;
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // The trailing odd column of an odd-width map can present an index past the end.
    // That pixel is discarded, so its read value is never used.
    assign rd_data_o = (int'(rd_idx_i) < POOL_W) ? mem_q[rd_idx_i] : '0;

endmodule

// File: rtl/relu_maxpool.sv
// relu_maxpool: applies ReLU to a raster-order conv pixel stream, then 2x2/stride-2 max-pooling.
//   clk, rst   : clock and asynchronous active-high reset.
//   in_valid   : in_data carries a signed conv pixel.
//   in_ready   : the block accepts in_data this cycle. It is low only while an output is stalled.
//   in_data    : signed conv pixel.
//   out_valid  : out_data holds a pooled pixel.
//   out_ready  : the consumer takes out_data this cycle.
//   out_data   : pooled pixel. It is never negative.
//   frame_done : one-cycle pulse, one cycle after the frame's last pixel is accepted.
module relu_maxpool
    import relu_maxpool_pkg::*;
#(
    parameter int DATA_W = OUTPUT_BITWIDTH,
    parameter int FMAP_W = DEF_FMAP,
    parameter int FMAP_H = DEF_FMAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_done
);

    localparam int POOL_W = FMAP_W / 2;
    localparam int CW     = clog2_min1(FMAP_W);
    localparam int RW     = clog2_min1(FMAP_H);
    localparam int PW     = clog2_min1(POOL_W);
    localparam logic [CW-1:0] COL_LAST = CW'(FMAP_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FMAP_H - 1);

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] h_q, h_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              frame_done_q, frame_done_d;

    logic              accept, col_last, row_last, discard;
    logic              lb_we, load;
    logic [PW-1:0]     p_idx;
    logic [DATA_W-1:0] relu, lb_rd, mx_src, mx;

    // There is a single output register and no skid buffer.
    // Input stalls only while a result is waiting and the consumer is not taking it.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign relu     = in_data[DATA_W-1] ? '0 : in_data;
    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);
    // The trailing column or row of an odd dimension has no partner and is dropped.
    assign discard  = (((FMAP_W % 2) != 0) && col_last) || (((FMAP_H % 2) != 0) && row_last);
    assign p_idx    = PW'(col_q >> 1);

    // Only the odd-row/even-col step merges with the line buffer.
    // Every other step merges with the hold register.
    // Both operands are >= 0, so an unsigned compare is correct.
    assign mx_src = (row_q[0] && !col_q[0]) ? lb_rd : h_q;
    assign mx     = (mx_src > relu) ? mx_src : relu;

    assign lb_we = accept && !discard && !row_q[0] &&  col_q[0];
    assign load  = accept && !discard &&  row_q[0] &&  col_q[0];

    pool_linebuf #(
        .DATA_W (DATA_W),
        .POOL_W (POOL_W),
        .IDX_W  (PW)
    ) u_linebuf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (lb_we),
        .wr_idx_i  (p_idx),
        .wr_data_i (mx),
        .rd_idx_i  (p_idx),
        .rd_data_o (lb_rd)
    );

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        h_d          = h_q;
        frame_done_d = accept && col_last && row_last;
        if (accept) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) row_d = row_last ? '0 : row_q + 1'b1;
            if (!discard && !col_q[0]) h_d = row_q[0] ? mx : relu;
        end
        // A load during a drain keeps valid high and replaces the data.
        out_valid_d = load || (out_valid_q && !out_ready);
        out_data_d  = load ? mx : out_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            h_q          <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            h_q          <= h_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// tb_relu_maxpool: randomized and directed bench for relu_maxpool.
// Instance 0 is the 5x5 default map; instance 1 is a 6x6 map.
// A frame-array model predicts each pooled pixel and the timing of frame_done.
module tb_relu_maxpool;

    localparam int DW = 16;
    localparam int RAMP = 0, NEG = 1, RND = 2, MIX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid   [2];
    logic          in_ready   [2];
    logic [DW-1:0] in_data    [2];
    logic          out_valid  [2];
    logic          out_ready  [2];
    logic [DW-1:0] out_data   [2];
    logic          frame_done [2];

    always #5 clk = ~clk;

    relu_maxpool #(.DATA_W(DW), .FMAP_W(5), .FMAP_H(5)) u_dut5 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .frame_done(frame_done[0])
    );

    relu_maxpool #(.DATA_W(DW), .FMAP_W(6), .FMAP_H(6)) u_dut6 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .frame_done(frame_done[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int fw(input int u);
        return (u == 0) ? 5 : 6;
    endfunction

    function automatic logic [DW-1:0] relu_f(input logic [DW-1:0] d);
        return d[DW-1] ? '0 : d;
    endfunction

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // ---------------- reference model state ----------------
    logic [DW-1:0] fr      [2][36];   // ReLU'd frame, row-major
    logic [DW-1:0] expm    [2][64];   // expected pooled outputs, ring buffer
    logic [DW-1:0] out_log [2][64];
    logic [DW-1:0] hold_data [2];
    int  pix [2], wp [2], rp [2], fd_cnt [2], out_n [2];
    bit  fd_exp [2], lat_exp [2], hold_prev [2];
    int  stall_cnt = 0;
    bit  bp_hold   = 1'b0;
    int  m_r, m_c, m_w, m_b;
    bit  m_fd;

    initial begin
        for (int u = 0; u < 2; u++) begin
            pix[u] = 0; wp[u] = 0; rp[u] = 0; fd_cnt[u] = 0; out_n[u] = 0;
            fd_exp[u] = 0; lat_exp[u] = 0; hold_prev[u] = 0; hold_data[u] = '0;
        end
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (rst) begin
                    pix[u] = 0; wp[u] = 0; rp[u] = 0;
                    fd_exp[u] = 0; lat_exp[u] = 0; hold_prev[u] = 0;
                end else begin
                    m_w = fw(u);
                    chk("frame_done", frame_done[u], fd_exp[u]);
                    if (frame_done[u]) fd_cnt[u]++;
                    if (lat_exp[u]) chk("latency_valid", out_valid[u], 1);
                    lat_exp[u] = 0;
                    if (hold_prev[u]) begin
                        chk("hold_valid", out_valid[u], 1);
                        chk("hold_data", out_data[u], hold_data[u]);
                    end
                    hold_prev[u] = 0;
                    if (out_valid[u] && !out_ready[u]) begin
                        chk("bp_in_ready", in_ready[u], 0);
                        hold_prev[u] = 1;
                        hold_data[u] = out_data[u];
                    end
                    if (out_valid[u] && out_ready[u]) begin
                        if (rp[u] == wp[u]) chk("spurious_out", out_valid[u], 0);
                        else begin
                            chk("pool_data", out_data[u], expm[u][rp[u] % 64]);
                            rp[u]++;
                        end
                        out_log[u][out_n[u] % 64] = out_data[u];
                        out_n[u]++;
                    end
                    m_fd = 0;
                    if (in_valid[u] && in_ready[u]) begin
                        m_r = pix[u] / m_w;
                        m_c = pix[u] % m_w;
                        fr[u][pix[u]] = relu_f(in_data[u]);
                        if ((m_r % 2 == 1) && (m_c % 2 == 1) &&
                            (m_c < 2 * (m_w / 2)) && (m_r < 2 * (m_w / 2))) begin
                            m_b = (m_r - 1) * m_w + (m_c - 1);
                            expm[u][wp[u] % 64] = max2(max2(fr[u][m_b], fr[u][m_b + 1]),
                                                       max2(fr[u][m_b + m_w], fr[u][m_b + m_w + 1]));
                            wp[u]++;
                            lat_exp[u] = 1;
                        end
                        if (pix[u] == m_w * m_w - 1) begin
                            m_fd = 1;
                            pix[u] = 0;
                        end else pix[u]++;
                    end
                    fd_exp[u] = m_fd;
                    if (u == 1 && in_valid[1] && !in_ready[1] && out_ready[1]) stall_cnt++;
                end
            end
        end
    end

    // ---------------- drivers (entered and left at posedge + 1) ----------------
    task automatic send_px(input int u, input logic [DW-1:0] d, input int vld_pct, input int rdy_pct);
        int  guard;
        bit  done;
        while (int'($urandom_range(99)) >= vld_pct) begin
            in_valid[u] = 1'b0;
            if (!bp_hold) out_ready[u] = (int'($urandom_range(99)) < rdy_pct);
            @(posedge clk); #1;
        end
        in_valid[u] = 1'b1;
        in_data[u]  = d;
        done  = 0;
        guard = 0;
        while (!done) begin
            if (!bp_hold) out_ready[u] = (int'($urandom_range(99)) < rdy_pct);
            @(negedge clk);
            done = in_ready[u];
            guard++;
            @(posedge clk); #1;
            if (!done && guard > 200) begin
                chk("in_ready_timeout", in_ready[u], 1);
                done = 1;
            end
        end
    endtask

    task automatic send_frame(input int u, input int kind, input int vld_pct, input int rdy_pct);
        int w;
        logic [DW-1:0] d;
        w = fw(u);
        for (int k = 0; k < w * w; k++) begin
            d = 16'($urandom());
            case (kind)
                RAMP: d = 16'(16 * k);
                NEG:  d = 16'hFFF0;
                MIX: begin
                    if (k == 0)     d = 16'hFFFB;
                    if (k == 1)     d = 16'h0003;
                    if (k == w)     d = 16'h7FFF;
                    if (k == w + 1) d = 16'hFFFF;
                end
                default: ;
            endcase
            send_px(u, d, vld_pct, rdy_pct);
        end
    endtask

    task automatic drain(input int u);
        int g;
        in_valid[u]  = 1'b0;
        out_ready[u] = 1'b1;
        g = 0;
        while ((rp[u] != wp[u] || out_valid[u]) && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        repeat (2) begin @(posedge clk); #1; end
        chk("drain_left", 32'(wp[u] - rp[u]), 0);
    endtask

    task automatic clear_log(input int u);
        out_n[u]  = 0;
        fd_cnt[u] = 0;
    endtask

    task automatic chk_ramp(input string tag);
        chk({tag, "_count"}, 32'(out_n[0]), 4);
        chk({tag, "_0"}, out_log[0][0], 96);
        chk({tag, "_1"}, out_log[0][1], 128);
        chk({tag, "_2"}, out_log[0][2], 256);
        chk({tag, "_3"}, out_log[0][3], 288);
        chk({tag, "_fd"}, 32'(fd_cnt[0]), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 1'b0; in_data[u] = '0; out_ready[u] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("reset_out_valid", out_valid[u], 0);
            chk("reset_out_data", out_data[u], 0);
            chk("reset_frame_done", frame_done[u], 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready0", in_ready[0], 1);
        chk("post_reset_in_ready1", in_ready[1], 1);

        // Ramp frame, consumer always ready
        clear_log(0);
        send_frame(0, RAMP, 100, 100);
        drain(0);
        chk_ramp("ramp");

        // All-negative frame: every pooled pixel is 0
        clear_log(0);
        send_frame(0, NEG, 100, 100);
        drain(0);
        chk("neg_count", 32'(out_n[0]), 4);
        for (int i = 0; i < 4; i++) chk("neg_val", out_log[0][i], 0);

        // Mixed-sign window at (0,0)
        clear_log(0);
        send_frame(0, MIX, 80, 80);
        drain(0);
        chk("mix_window", out_log[0][0], 16'h7FFF);

        // Backpressure: the first result is held while out_ready is low
        clear_log(0);
        fork
            send_frame(0, RAMP, 100, 100);
            begin
                int g;
                bp_hold = 1'b1;
                out_ready[0] = 1'b0;
                g = 0;
                do begin @(negedge clk); g++; end while (!out_valid[0] && g < 40);
                chk("bp_first_valid", out_valid[0], 1);
                chk("bp_first_data", out_data[0], 96);
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_stall_in_ready", in_ready[0], 0);
                    chk("bp_stall_data", out_data[0], 96);
                end
                @(posedge clk); #1;
                out_ready[0] = 1'b1;
                bp_hold = 1'b0;
            end
        join
        drain(0);
        chk_ramp("bp");

        // Reset in the middle of a frame, then a fresh ramp
        for (int k = 0; k < 12; k++) send_px(0, 16'($urandom()), 100, 50);
        rst = 1'b1;
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid[0], 0);
        chk("midrst_out_data", out_data[0], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_log(0);
        send_frame(0, RAMP, 100, 100);
        drain(0);
        chk_ramp("midrst");

        // Random frames with random gaps and backpressure, back to back
        for (int f = 0; f < 4; f++) send_frame(0, RND, 70, 60);
        drain(0);

        // 6x6 map: two back-to-back frames with no gaps and no stalls
        clear_log(1);
        stall_cnt = 0;
        send_frame(1, RND, 100, 100);
        send_frame(1, RAMP, 100, 100);
        drain(1);
        chk("b2b_count", 32'(out_n[1]), 18);
        chk("b2b_fd", 32'(fd_cnt[1]), 2);
        chk("b2b_stalls", 32'(stall_cnt), 0);

        // 6x6 map with random handshake
        for (int f = 0; f < 3; f++) send_frame(1, RND, 75, 50);
        drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
